// File: rtl/uart2vga_pkg.sv
// rtl/uart2vga_pkg.sv - shared UART-to-VGA frame geometry and types
package uart2vga_pkg;
    localparam int WIDTH  = 640;
    localparam int HEIGHT = 480;
    localparam int PIX_W  = 3;
    localparam int ADDR_W = 19;
    localparam int ROW_W  = 9;

    typedef enum logic [1:0] {IDLE, BASE, WRITE, DONE} fbw_state_t;
    typedef logic [PIX_W-1:0] pixel_t;
endpackage

// File: rtl/uart_row_fb_writer.sv
// rtl/uart_row_fb_writer.sv - writes one received pixel row into the frame buffer
module uart_row_fb_writer
    import uart2vga_pkg::*;
#(
    parameter int WIDTH  = uart2vga_pkg::WIDTH,
    parameter int HEIGHT = uart2vga_pkg::HEIGHT,
    parameter int PIX_W  = uart2vga_pkg::PIX_W,
    parameter int ADDR_W = uart2vga_pkg::ADDR_W,
    parameter int ROW_W  = uart2vga_pkg::ROW_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIX_W*WIDTH-1:0] row_data,
    input  logic [ROW_W-1:0]       row_idx,
    input  logic                   row_valid,
    output logic                   row_ready,
    input  logic                   stall,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [PIX_W-1:0]       ram_data,
    output logic                   ram_we,
    output logic                   row_done,
    output logic                   busy,
    input  logic                   clr_flags,
    output logic                   overrun,
    output logic                   bad_row
);
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    fbw_state_t             state;
    logic [PIX_W*WIDTH-1:0] shreg;
    logic [ROW_W-1:0]       idx_q;
    logic [ADDR_W-1:0]      base;
    logic [COL_W-1:0]       col;
    logic                   accept;
    logic                   legal;

    // row_ready is only ever high in IDLE, so accept implies IDLE
    assign accept = row_valid && row_ready;
    assign legal  = int'(row_idx) < HEIGHT;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row_ready <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_data  <= '0;
            row_done  <= 1'b0;
            shreg     <= '0;
            idx_q     <= '0;
            base      <= '0;
            col       <= '0;
        end else begin
            ram_we    <= 1'b0;
            row_done  <= 1'b0;
            // ready returns one cycle after DONE hands back to IDLE
            row_ready <= (state == IDLE) && !(accept && legal);
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= row_data;
                        idx_q <= row_idx;
                        if (legal) state <= BASE;
                    end
                end
                BASE: begin
                    base  <= ADDR_W'(idx_q) * ADDR_W'(WIDTH);
                    col   <= '0;
                    state <= WRITE;
                end
                WRITE: begin
                    if (!stall) begin
                        ram_we   <= 1'b1;
                        ram_addr <= base + ADDR_W'(col);
                        ram_data <= shreg[PIX_W-1:0];
                        shreg    <= shreg >> PIX_W;
                        col      <= col + 1'b1;
                        if (col == COL_W'(WIDTH - 1)) state <= DONE;
                    end
                end
                DONE: begin
                    row_done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // a flag-setting event in the same cycle as clr_flags wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
            bad_row <= 1'b0;
        end else begin
            overrun <= (row_valid && !row_ready) || (overrun && !clr_flags);
            bad_row <= (accept && !legal) || (bad_row && !clr_flags);
        end
    end
endmodule

// File: tb/tb_uart_row_fb_writer.sv
// tb/tb_uart_row_fb_writer.sv - self-checking bench for uart_row_fb_writer
module tb_uart_row_fb_writer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] row_data = '0;
    logic [2:0]  row_idx = '0;
    logic        row_valid = 1'b0;
    logic        row_ready;
    logic        stall = 1'b0;
    logic [4:0]  ram_addr;
    logic [2:0]  ram_data;
    logic        ram_we;
    logic        row_done;
    logic        busy;
    logic        clr_flags = 1'b0;
    logic        overrun;
    logic        bad_row;

    logic [1919:0] bg_data = '0;
    logic [8:0]    bg_idx = '0;
    logic          bg_valid = 1'b0;
    logic          bg_ready;
    logic          bg_stall = 1'b0;
    logic [18:0]   bg_addr;
    logic [2:0]    bg_wdata;
    logic          bg_we;
    logic          bg_done;
    logic          bg_busy;
    logic          bg_clr = 1'b0;
    logic          bg_overrun;
    logic          bg_bad;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_row_fb_writer #(.WIDTH(8), .HEIGHT(4), .PIX_W(3), .ADDR_W(5), .ROW_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .row_data(row_data), .row_idx(row_idx),
        .row_valid(row_valid), .row_ready(row_ready), .stall(stall),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .row_done(row_done), .busy(busy), .clr_flags(clr_flags),
        .overrun(overrun), .bad_row(bad_row)
    );

    uart_row_fb_writer u_big (
        .clk(clk), .rst_n(rst_n), .row_data(bg_data), .row_idx(bg_idx),
        .row_valid(bg_valid), .row_ready(bg_ready), .stall(bg_stall),
        .ram_addr(bg_addr), .ram_data(bg_wdata), .ram_we(bg_we),
        .row_done(bg_done), .busy(bg_busy), .clr_flags(bg_clr),
        .overrun(bg_overrun), .bad_row(bg_bad)
    );

    typedef struct {
        int          idx;
        logic [23:0] data;
        logic [39:0] smask;
        int          exp_done;
        int          exp_ready;
        int          ovr_c;
        bit          ovr_clr;
    } vec_t;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: writes land on the first 8 non-stalled cycles from cycle 2 on,
    // row_done one cycle after the last write, row_ready one cycle after that.
    task automatic run_row(input vec_t v);
        int  exp_cyc[8];
        int  k, wi, ndone, dc, rc, nr, exp_done, exp_ready;
        bit  legal;
        legal = v.idx < 4;
        k = 0;
        for (int c = 2; c < 40 && k < 8; c++)
            if (!v.smask[c]) begin
                exp_cyc[k] = c;
                k++;
            end
        exp_done  = (v.exp_done >= 0) ? v.exp_done : exp_cyc[7] + 1;
        exp_ready = (v.exp_ready >= 0) ? v.exp_ready : (legal ? exp_cyc[7] + 2 : 1);

        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        row_idx   = 3'(v.idx);
        row_data  = v.data;
        row_valid = 1'b1;
        stall     = 1'b0;
        tick();
        row_valid = 1'b0;
        row_data  = 24'($urandom);
        check_eq("bad_row_after_accept", int'(bad_row), int'(!legal));
        check_eq("busy_after_accept", int'(busy), int'(legal));

        wi = 0; ndone = 0; dc = -1; rc = -1; nr = 0;
        for (int c = 1; c <= 44; c++) begin
            stall = (c < 40) ? v.smask[c] : 1'b0;
            if (c == v.ovr_c) begin
                row_valid = 1'b1;
                row_idx   = 3'($urandom);
                row_data  = 24'($urandom);
                clr_flags = v.ovr_clr;
            end
            tick();
            row_valid = 1'b0;
            clr_flags = 1'b0;
            if (ram_we) begin
                if (wi < 8) begin
                    check_eq("write_cycle", c, exp_cyc[wi]);
                    check_eq("write_addr", int'(ram_addr), v.idx * 8 + wi);
                    check_eq("write_data", int'(ram_data), int'(v.data[wi*3 +: 3]));
                end
                wi++;
            end
            if (row_done) begin
                ndone++;
                dc = c;
            end
            if (!row_ready) nr++;
            if (row_ready && rc < 0) rc = c;
        end
        stall = 1'b0;
        check_eq("write_count", wi, legal ? 8 : 0);
        check_eq("done_count", ndone, legal ? 1 : 0);
        if (legal) check_eq("done_cycle", dc, exp_done);
        else check_eq("not_ready_cycles", nr, 0);
        check_eq("ready_cycle", rc, exp_ready);
        check_eq("overrun", int'(overrun), int'(v.ovr_c > 0));
        if (v.ovr_c > 0) begin
            clr_flags = 1'b1;
            tick();
            clr_flags = 1'b0;
            check_eq("overrun_cleared", int'(overrun), 0);
        end
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        int   cnt;
        int   last_a, last_d;
        bit   seen_done;

        tbl[0] = '{2, 24'o76543210, 40'h0,   10, 11, -1, 1'b0};
        tbl[1] = '{2, 24'o76543210, 40'h98,  13, 14, -1, 1'b0};
        tbl[2] = '{2, 24'o76543210, 40'h0,   10, 11,  4, 1'b0};
        tbl[3] = '{4, 24'o76543210, 40'h0,   -1,  1, -1, 1'b0};
        tbl[4] = '{3, 24'o01234567, 40'h4,   11, 12,  1, 1'b1};
        tbl[5] = '{0, 24'o55555555, 40'h200, 11, 12, -1, 1'b0};

        tick();
        check_eq("rst_row_ready", int'(row_ready), 1);
        check_eq("rst_ram_we", int'(ram_we), 0);
        check_eq("rst_ram_addr", int'(ram_addr), 0);
        check_eq("rst_ram_data", int'(ram_data), 0);
        check_eq("rst_row_done", int'(row_done), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_flags", int'({overrun, bad_row}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_row(tbl[i]);

        for (int i = 0; i < 20; i++) begin
            v.idx       = $urandom_range(0, 5);
            v.data      = 24'($urandom);
            v.smask     = 40'($urandom & $urandom) & 40'h0FFFFC;
            v.exp_done  = -1;
            v.exp_ready = -1;
            v.ovr_c     = (v.idx < 4 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : -1;
            v.ovr_clr   = 1'($urandom);
            run_row(v);
        end

        // asynchronous reset in the middle of a row
        row_idx   = 3'd1;
        row_data  = 24'($urandom);
        row_valid = 1'b1;
        tick();
        row_valid = 1'b0;
        for (int c = 1; c <= 5; c++) tick();
        check_eq("midrow_we_before_reset", int'(ram_we), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrow_rst_we", int'(ram_we), 0);
        check_eq("midrow_rst_addr", int'(ram_addr), 0);
        check_eq("midrow_rst_data", int'(ram_data), 0);
        check_eq("midrow_rst_ready", int'(row_ready), 1);
        check_eq("midrow_rst_busy", int'(busy), 0);
        check_eq("midrow_rst_done", int'(row_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        v = '{0, 24'($urandom), 40'h0, 10, 11, -1, 1'b0};
        run_row(v);

        // default geometry: last row of the frame
        for (int i = 0; i < 640; i++) bg_data[i*3 +: 3] = 3'($urandom);
        bg_data[639*3 +: 3] = 3'd5;
        bg_idx   = 9'd479;
        bg_valid = 1'b1;
        tick();
        bg_valid = 1'b0;
        cnt = 0; last_a = -1; last_d = -1; seen_done = 1'b0;
        for (int c = 1; c <= 700 && !seen_done; c++) begin
            tick();
            if (bg_we) begin
                if (cnt == 0) begin
                    check_eq("big_first_addr", int'(bg_addr), 306560);
                    check_eq("big_first_data", int'(bg_wdata), int'(bg_data[2:0]));
                end
                cnt++;
                last_a = int'(bg_addr);
                last_d = int'(bg_wdata);
            end
            if (bg_done) seen_done = 1'b1;
        end
        check_eq("big_done_seen", int'(seen_done), 1);
        check_eq("big_write_count", cnt, 640);
        check_eq("big_last_addr", last_a, 307199);
        check_eq("big_last_data", last_d, 5);
        check_eq("big_bad_row", int'(bg_bad), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
